dm_pipe: RTL and testbench

- Parametrised data memory for the pipelined CPU. Successor to the single-cycle DM.
- Valid/ready request interface with configurable read latency.
- Internal byte-lane decode and sign/zero extraction for word/half/byte accesses.
- Flags misaligned, out-of-range and illegal-size accesses; a post-reset hardware sweep zeroes the array.

---
 rtl/dm_pipe.sv | 156 +++++++++++++++
 tb/tb_dm_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_pipe.sv
// Pipelined data memory: byte-lane stores, sign/zero-extended loads, fault flags, post-reset zeroing sweep.
// Latency: response RD_LATENCY cycles after the accept edge (1..4). Optional store trace under DM_PIPE_TRACE_EN.
// Backpressure: Ready=0 during the sweep only; the response path cannot stall.
module dm_pipe #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    output logic        Ready,
    input  logic        We,
    input  logic [1:0]  Size,
    input  logic        SignRead,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [31:0] WPC,
    output logic        RespValid,
    output logic        RespExc,
    output logic [1:0]  RespCode,
    output logic [31:0] RD
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic        vld;
        logic        exc;
        logic [1:0]  code;
        logic [31:0] rd;
    } resp_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH_WORDS];
    resp_t         pipe [RD_LATENCY];

    logic          accept;
    logic [31:0]   off;
    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [1:0]    code;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   lane_dat;
    logic [31:0]   merged_word;
    logic [15:0]   half_dat;
    logic [7:0]    byte_dat;
    logic [31:0]   rd_dat;

    assign Ready    = (state == RUN);
    assign accept   = Req && Ready;
    assign off      = Addr - BASE_ADDR;
    assign word_idx = off[AW+1:2];
    assign old_word = mem[word_idx];
    assign fault    = (code != 2'd0);
    assign half_dat = off[1] ? old_word[31:16] : old_word[15:0];
    assign byte_dat = old_word[{off[1:0], 3'b000} +: 8];

    // Priority: illegal size, then misalignment, then range.
    always_comb begin
        code = 2'd0;
        if (Size == 2'd3)
            code = 2'd3;
        else if ((Size == 2'd0 && off[1:0] != 2'b00) || (Size == 2'd1 && off[0]))
            code = 2'd1;
        else if ({1'b0, off} >= MEM_BYTES)
            code = 2'd2;
    end

    always_comb begin
        be       = 4'b0000;
        lane_dat = WD;
        case (Size)
            2'd0: be = 4'b1111;
            2'd1: begin
                be       = off[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{WD[15:0]}};
            end
            2'd2: begin
                be       = 4'b0001 << off[1:0];
                lane_dat = {4{WD[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++)
            merged_word[8*i +: 8] = be[i] ? lane_dat[8*i +: 8] : old_word[8*i +: 8];
    end

    always_comb begin
        rd_dat = 32'd0;
        if (!We && !fault) begin
            case (Size)
                2'd0:    rd_dat = old_word;
                2'd1:    rd_dat = {{16{SignRead & half_dat[15]}}, half_dat};
                2'd2:    rd_dat = {{24{SignRead & byte_dat[7]}}, byte_dat};
                default: rd_dat = 32'd0;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= INIT;
            idx   <= '0;
        end else if (state == INIT) begin
            idx <= idx + 1'b1;
            if (idx == AW'(DEPTH_WORDS - 1))
                state <= RUN;
        end
    end

    // Array has no reset; the sweep clears it and accepts are blocked until it finishes.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state == INIT)
                mem[idx] <= 32'd0;
            else if (accept && We && !fault)
                mem[word_idx] <= merged_word;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < RD_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= accept ? '{vld: 1'b1, exc: fault, code: code, rd: rd_dat} : '0;
            for (int i = 1; i < RD_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign RespValid = pipe[RD_LATENCY-1].vld;
    assign RespExc   = pipe[RD_LATENCY-1].exc;
    assign RespCode  = pipe[RD_LATENCY-1].code;
    assign RD        = pipe[RD_LATENCY-1].rd;

`ifdef DM_PIPE_TRACE_EN
    always @(posedge Clock) begin
        if (!Reset && accept && We) begin
            if (fault)
                $display("%d@%h: DM fault %0d addr %h", $time, WPC, code, Addr);
            else
                $display("%d@%h: *%h <= %h", $time, WPC, {Addr[31:2], 2'b00}, merged_word);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^WPC;
`endif

endmodule

// File: tb/tb_dm_pipe.sv
// Bench for dm_pipe: directed vector table, sweep/reset sequences, random traffic against a byte-array model.
module tb_dm_pipe;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          LAT   = 3;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0, We = 1'b0, SignRead = 1'b0;
    logic [1:0]  Size = 2'd0;
    logic [31:0] Addr = 32'd0, WD = 32'd0, WPC = 32'd0;
    logic        Ready, RespValid, RespExc;
    logic [1:0]  RespCode;
    logic [31:0] RD;

    dm_pipe #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(LAT)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Ready(Ready), .We(We), .Size(Size),
        .SignRead(SignRead), .Addr(Addr), .WD(WD), .WPC(WPC), .RespValid(RespValid),
        .RespExc(RespExc), .RespCode(RespCode), .RD(RD)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic        exc;
        logic [1:0]  code;
        logic [31:0] rd;
    } exp_t;
    exp_t q[$];

    logic [7:0] bytes [4*DEPTH];

    task automatic model_clear();
        for (int i = 0; i < 4*DEPTH; i++) bytes[i] = 8'h00;
    endtask

    // Reference: memory as a flat little-endian byte array.
    function automatic void model(input logic we, input logic [1:0] size, input logic sign,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic exc, output logic [1:0] code, output logic [31:0] rd);
        logic [31:0] off;
        int n;
        off  = addr - BASE;
        n    = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        exc  = 1'b0;
        code = 2'd0;
        rd   = 32'd0;
        if (size == 2'd3) code = 2'd3;
        else if ((off % n) != 0) code = 2'd1;
        else if (off >= 4*DEPTH) code = 2'd2;
        if (code != 2'd0) begin
            exc = 1'b1;
            return;
        end
        if (we) begin
            for (int k = 0; k < n; k++) bytes[off + k] = 8'(wd >> (8*k));
        end else begin
            for (int k = 0; k < n; k++) rd = rd | (32'(bytes[off + k]) << (8*k));
            if (sign && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
        end
    endfunction

    // Response checker: every cycle either the due response or fully idle outputs.
    always @(negedge Clock) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("resp_valid", 64'(RespValid), 64'd1);
            chk("resp_exc",   64'(RespExc), 64'(e.exc));
            chk("resp_code",  64'(RespCode), 64'(e.code));
            chk("resp_rd",    64'(RD), 64'(e.rd));
        end else begin
            chk("idle_outputs", 64'({RespValid, RespExc, RespCode, RD}), 64'd0);
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wd, input bit use_tab,
                         input logic texc, input logic [1:0] tcode, input logic [31:0] trd);
        exp_t e;
        chk("ready_run", 64'(Ready), 64'd1);
        Req = 1'b1; We = we; Size = size; SignRead = sign; Addr = addr; WD = wd;
        WPC = WPC + 32'd4;
        @(posedge Clock);
        #1;
        model(we, size, sign, addr, wd, e.exc, e.code, e.rd);
        e.due = cyc + LAT - 1;
        if (use_tab) begin
            e.exc = texc; e.code = tcode; e.rd = trd;
        end
        q.push_back(e);
        Req = 1'b0;
    endtask

    task automatic idle(input int n);
        Req = 1'b0;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Counts Ready=0 cycles after reset release, with a stuck store request offered throughout.
    task automatic sweep_check();
        int n = 0;
        Req = 1'b1; We = 1'b1; Size = 2'd0; Addr = 32'h0; WD = 32'hFFFF_FFFF;
        forever begin
            @(negedge Clock);
            if (Ready || n > 100) break;
            n++;
        end
        Req = 1'b0;
        chk("init_cycles", 64'(n), 64'(DEPTH));
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        q.delete();
        model_clear();
        repeat (n) @(posedge Clock);
        #1;
        chk("ready_in_reset", 64'(Ready), 64'd0);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exc;
        logic [1:0]  code;
        logic [31:0] rd;
    } vec_t;
    vec_t tab[20];

    initial begin
        tab[0]  = '{1'b1, 2'd0, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 2'd0, 32'h0};
        tab[1]  = '{1'b1, 2'd2, 1'b0, 32'h13, 32'h0000_00AA, 1'b0, 2'd0, 32'h0};
        tab[2]  = '{1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_BEEF, 1'b0, 2'd0, 32'h0};
        tab[3]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,         1'b0, 2'd0, 32'hAA22_BEEF};
        tab[4]  = '{1'b0, 2'd2, 1'b1, 32'h13, 32'h0,         1'b0, 2'd0, 32'hFFFF_FFAA};
        tab[5]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,         1'b0, 2'd0, 32'h0000_BEEF};
        tab[6]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,         1'b0, 2'd0, 32'h0000_0022};
        tab[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,         1'b0, 2'd0, 32'hFFFF_AA22};
        tab[8]  = '{1'b1, 2'd0, 1'b0, 32'h00, 32'h5566_7788, 1'b0, 2'd0, 32'h0};
        tab[9]  = '{1'b0, 2'd0, 1'b0, 32'h02, 32'h0,         1'b1, 2'd1, 32'h0};
        tab[10] = '{1'b1, 2'd1, 1'b0, 32'h01, 32'h0000_1234, 1'b1, 2'd1, 32'h0};
        tab[11] = '{1'b0, 2'd0, 1'b0, 32'h00, 32'h0,         1'b0, 2'd0, 32'h5566_7788};
        tab[12] = '{1'b1, 2'd0, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b1, 2'd2, 32'h0};
        tab[13] = '{1'b0, 2'd3, 1'b0, 32'h04, 32'h0,         1'b1, 2'd3, 32'h0};
        tab[14] = '{1'b1, 2'd3, 1'b0, 32'h41, 32'h0,         1'b1, 2'd3, 32'h0};
        tab[15] = '{1'b0, 2'd0, 1'b0, 32'h42, 32'h0,         1'b1, 2'd1, 32'h0};
        tab[16] = '{1'b1, 2'd0, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 2'd0, 32'h0};
        tab[17] = '{1'b0, 2'd0, 1'b0, 32'h20, 32'h0,         1'b0, 2'd0, 32'hCAFE_F00D};
        tab[18] = '{1'b1, 2'd2, 1'b0, 32'h3F, 32'h0000_0080, 1'b0, 2'd0, 32'h0};
        tab[19] = '{1'b0, 2'd2, 1'b1, 32'h3F, 32'h0,         1'b0, 2'd0, 32'hFFFF_FF80};

        model_clear();
        repeat (3) @(posedge Clock);
        #1;
        do_reset(1);
        sweep_check();

        for (int w = 0; w < DEPTH; w++)
            issue(1'b0, 2'd0, 1'b0, 32'(4*w), 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
        idle(LAT + 1);

        for (int i = 0; i < 20; i++)
            issue(tab[i].we, tab[i].size, tab[i].sign, tab[i].addr, tab[i].wd,
                  1'b1, tab[i].exc, tab[i].code, tab[i].rd);
        idle(LAT + 1);

        // Reset with two loads still in flight; neither may surface, data must be wiped.
        issue(1'b1, 2'd0, 1'b0, 32'h30, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
        do_reset(3);
        sweep_check();
        issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
        idle(LAT + 1);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 4*DEPTH + 7)), $urandom, 1'b0, 1'b0, 2'd0, 32'h0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
